jtag_dma_ctrl: RTL and testbench

- Bus-side controller for the JTAG ping-pong buffer.
- On a launch pulse from the JTAG chain controller, it takes the DMA-owned half of the ping-pong buffer and runs one burst on the system bus: a write (buffer → bus) or a read (bus → buffer).
- Drives switch_ready, which tells the chain controller when it may swap buffer halves.
- Owns the bus-master request/grant handshake, beat sequencing, error abort and read timeout.

---
 rtl/jtag_dma_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_jtag_dma_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dma_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : jtag_dma_ctrl
// Brief  : Bus-side burst engine for the DMA half of the JTAG ping-pong buffer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module jtag_dma_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PP_ADDR_WIDTH  = 9,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     JTCK,
    input  logic                     JRSTN,
    input  logic [ADDR_WIDTH-1:0]    dma_address,
    input  logic [3:0]               dma_byte_enable,
    input  logic [7:0]               dma_burst_size,
    input  logic                     dma_data_ready,
    input  logic                     dma_readReady,
    output logic                     switch_ready,
    output logic [PP_ADDR_WIDTH-1:0] pp_address,
    output logic                     pp_writeEnable,
    output logic [DATA_WIDTH-1:0]    pp_dataIn,
    input  logic [DATA_WIDTH-1:0]    pp_dataOut,
    output logic                     bus_request,
    input  logic                     bus_grant,
    output logic                     bus_begin,
    output logic                     bus_read_nwrite,
    output logic [ADDR_WIDTH-1:0]    bus_address_out,
    output logic [7:0]               bus_burst_size,
    output logic [3:0]               bus_byte_enable_out,
    output logic [DATA_WIDTH-1:0]    bus_data_out,
    output logic                     bus_data_valid,
    input  logic                     bus_busy,
    input  logic [DATA_WIDTH-1:0]    bus_data_in,
    input  logic                     bus_data_in_valid,
    output logic                     bus_end,
    input  logic                     bus_error,
    output logic                     dma_busy,
    output logic [2:0]               dma_status
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_BEGIN, S_WR_FETCH, S_WR_LOAD,
        S_WR_BEAT, S_WR_END, S_RD_BEAT, S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [3:0]               be_q, be_d;
    logic [7:0]               n_q, n_d;
    logic                     rd_q, rd_d;
    logic [7:0]               k_q, k_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    logic [2:0]               status_q, status_d;
    logic                     switch_ready_q, switch_ready_d;
    logic [PP_ADDR_WIDTH-1:0] pp_addr_q, pp_addr_d;
    logic                     pp_we_q, pp_we_d;
    logic [DATA_WIDTH-1:0]    pp_din_q, pp_din_d;
    logic                     req_q, req_d;
    logic                     begin_q, begin_d;
    logic                     rnw_q, rnw_d;
    logic [ADDR_WIDTH-1:0]    baddr_q, baddr_d;
    logic [7:0]               bsize_q, bsize_d;
    logic [3:0]               bbe_q, bbe_d;
    logic [DATA_WIDTH-1:0]    bdo_q, bdo_d;
    logic                     bvalid_q, bvalid_d;
    logic                     bend_q, bend_d;
    logic                     busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        n_d       = n_q;
        rd_d      = rd_q;
        k_d       = k_q;
        idle_d    = idle_q;
        status_d  = status_q;
        pp_addr_d = pp_addr_q;
        pp_we_d   = 1'b0;
        pp_din_d  = pp_din_q;
        bdo_d     = bdo_q;

        if (state_q != S_IDLE && (dma_data_ready || dma_readReady))
            status_d[2] = 1'b1;

        case (state_q)
            S_IDLE: begin
                // A simultaneous read launch loses to the write
                if (dma_data_ready || dma_readReady) begin
                    addr_d   = dma_address;
                    be_d     = dma_byte_enable;
                    n_d      = dma_burst_size;
                    rd_d     = !dma_data_ready;
                    status_d = 3'b000;
                    k_d      = 8'd0;
                    state_d  = S_REQ;
                end
            end
            S_REQ:      if (bus_grant) state_d = S_BEGIN;
            S_BEGIN: begin
                idle_d  = '0;
                state_d = rd_q ? S_RD_BEAT : S_WR_FETCH;
            end
            S_WR_FETCH: state_d = S_WR_LOAD;
            S_WR_LOAD: begin
                bdo_d   = pp_dataOut;
                state_d = S_WR_BEAT;
            end
            S_WR_BEAT: begin
                if (!bus_busy) begin
                    if (k_q == n_q) begin
                        state_d = S_WR_END;
                    end else begin
                        k_d     = k_q + 8'd1;
                        state_d = S_WR_FETCH;
                    end
                end
            end
            S_WR_END:   state_d = S_DONE;
            S_RD_BEAT: begin
                if (bus_data_in_valid) begin
                    pp_we_d   = 1'b1;
                    pp_addr_d = PP_ADDR_WIDTH'(k_q);
                    pp_din_d  = bus_data_in;
                    idle_d    = '0;
                    if (k_q == n_q) state_d = S_DONE;
                    else            k_d     = k_q + 8'd1;
                end else if (idle_q == TO_LAST) begin
                    status_d[1] = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            S_DONE: begin
                k_d     = 8'd0;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase

        // Slave error aborts whatever was in flight; a pending beat is dropped
        if (state_q != S_IDLE && bus_error) begin
            status_d[0] = 1'b1;
            if (state_q != S_DONE) begin
                state_d   = S_DONE;
                k_d       = k_q;
                idle_d    = idle_q;
                pp_we_d   = 1'b0;
                pp_addr_d = pp_addr_q;
                pp_din_d  = pp_din_q;
            end
        end

        if (state_d == S_WR_FETCH)
            pp_addr_d = PP_ADDR_WIDTH'(k_d);

        switch_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        req_d          = !switch_ready_d;
        begin_d        = (state_d == S_BEGIN);
        rnw_d          = begin_d ? rd_q : 1'b0;
        baddr_d        = begin_d ? addr_q : '0;
        bsize_d        = begin_d ? n_q : 8'd0;
        bbe_d          = begin_d ? be_q : 4'd0;
        bvalid_d       = (state_d == S_WR_BEAT);
        bend_d         = (state_d == S_WR_END);
    end

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            be_q           <= '0;
            n_q            <= '0;
            rd_q           <= 1'b0;
            k_q            <= '0;
            idle_q         <= '0;
            status_q       <= '0;
            switch_ready_q <= 1'b1;
            pp_addr_q      <= '0;
            pp_we_q        <= 1'b0;
            pp_din_q       <= '0;
            req_q          <= 1'b0;
            begin_q        <= 1'b0;
            rnw_q          <= 1'b0;
            baddr_q        <= '0;
            bsize_q        <= '0;
            bbe_q          <= '0;
            bdo_q          <= '0;
            bvalid_q       <= 1'b0;
            bend_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            n_q            <= n_d;
            rd_q           <= rd_d;
            k_q            <= k_d;
            idle_q         <= idle_d;
            status_q       <= status_d;
            switch_ready_q <= switch_ready_d;
            pp_addr_q      <= pp_addr_d;
            pp_we_q        <= pp_we_d;
            pp_din_q       <= pp_din_d;
            req_q          <= req_d;
            begin_q        <= begin_d;
            rnw_q          <= rnw_d;
            baddr_q        <= baddr_d;
            bsize_q        <= bsize_d;
            bbe_q          <= bbe_d;
            bdo_q          <= bdo_d;
            bvalid_q       <= bvalid_d;
            bend_q         <= bend_d;
            busy_q         <= busy_d;
        end
    end

    assign switch_ready        = switch_ready_q;
    assign pp_address          = pp_addr_q;
    assign pp_writeEnable      = pp_we_q;
    assign pp_dataIn           = pp_din_q;
    assign bus_request         = req_q;
    assign bus_begin           = begin_q;
    assign bus_read_nwrite     = rnw_q;
    assign bus_address_out     = baddr_q;
    assign bus_burst_size      = bsize_q;
    assign bus_byte_enable_out = bbe_q;
    assign bus_data_out        = bdo_q;
    assign bus_data_valid      = bvalid_q;
    assign bus_end             = bend_q;
    assign dma_busy            = busy_q;
    assign dma_status          = status_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dma_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_jtag_dma_ctrl
// Brief  : Directed self-checking bench for jtag_dma_ctrl.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_jtag_dma_ctrl;

    logic        JTCK = 1'b0;
    logic        JRSTN = 1'b0;
    logic [31:0] dma_address = '0;
    logic [3:0]  dma_byte_enable = '0;
    logic [7:0]  dma_burst_size = '0;
    logic        dma_data_ready = 1'b0;
    logic        dma_readReady = 1'b0;
    logic        switch_ready;
    logic [8:0]  pp_address;
    logic        pp_writeEnable;
    logic [31:0] pp_dataIn;
    logic [31:0] pp_dataOut;
    logic        bus_request;
    logic        bus_grant = 1'b0;
    logic        bus_begin;
    logic        bus_read_nwrite;
    logic [31:0] bus_address_out;
    logic [7:0]  bus_burst_size;
    logic [3:0]  bus_byte_enable_out;
    logic [31:0] bus_data_out;
    logic        bus_data_valid;
    logic        bus_busy = 1'b0;
    logic [31:0] bus_data_in = '0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_end;
    logic        bus_error = 1'b0;
    logic        dma_busy;
    logic [2:0]  dma_status;

    jtag_dma_ctrl dut (
        .JTCK(JTCK), .JRSTN(JRSTN),
        .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
        .dma_burst_size(dma_burst_size), .dma_data_ready(dma_data_ready),
        .dma_readReady(dma_readReady), .switch_ready(switch_ready),
        .pp_address(pp_address), .pp_writeEnable(pp_writeEnable),
        .pp_dataIn(pp_dataIn), .pp_dataOut(pp_dataOut),
        .bus_request(bus_request), .bus_grant(bus_grant), .bus_begin(bus_begin),
        .bus_read_nwrite(bus_read_nwrite), .bus_address_out(bus_address_out),
        .bus_burst_size(bus_burst_size), .bus_byte_enable_out(bus_byte_enable_out),
        .bus_data_out(bus_data_out), .bus_data_valid(bus_data_valid),
        .bus_busy(bus_busy), .bus_data_in(bus_data_in),
        .bus_data_in_valid(bus_data_in_valid), .bus_end(bus_end),
        .bus_error(bus_error), .dma_busy(dma_busy), .dma_status(dma_status)
    );

    always #5 JTCK = ~JTCK;

    // Buffer model: word i holds 0xA00000A0 + i, one-cycle read latency
    logic [31:0] mem [0:511];
    initial for (int i = 0; i < 512; i++) mem[i] = 32'hA000_00A0 + i;
    always @(posedge JTCK) pp_dataOut <= mem[pp_address];

    // Bus / buffer monitors
    int          begin_cnt = 0;
    int          end_cnt = 0;
    logic        cap_rnw;
    logic [31:0] cap_addr;
    logic [7:0]  cap_size;
    logic [3:0]  cap_be;
    logic [31:0] beats[$];
    logic [8:0]  pw_addr[$];
    logic [31:0] pw_data[$];

    always @(posedge JTCK) begin
        if (bus_begin) begin
            begin_cnt++;
            cap_rnw  = bus_read_nwrite;
            cap_addr = bus_address_out;
            cap_size = bus_burst_size;
            cap_be   = bus_byte_enable_out;
        end
        if (bus_end) end_cnt++;
        if (bus_data_valid && !bus_busy) beats.push_back(bus_data_out);
        if (pp_writeEnable) begin
            pw_addr.push_back(pp_address);
            pw_data.push_back(pp_dataIn);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge JTCK);
        #1;
    endtask

    task automatic launch(input logic wr, input logic rd, input logic [31:0] a, input logic [7:0] n);
        dma_address     = a;
        dma_byte_enable = 4'hF;
        dma_burst_size  = n;
        dma_data_ready  = wr;
        dma_readReady   = rd;
        tick();
        dma_data_ready  = 1'b0;
        dma_readReady   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dma_busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, dma_busy, 1'b0);
    endtask

    task automatic wait_begin(input string tag);
        int n = 0;
        while (!bus_begin && n < 50) begin
            tick();
            n++;
        end
        chk(tag, bus_begin, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, e0, bb, pw0, n;
        logic found;

        // Reset state
        repeat (3) tick();
        chk("rst_switch_ready", switch_ready, 1'b1);
        chk("rst_ctrl", {bus_request, bus_begin, bus_data_valid, bus_end, pp_writeEnable, dma_busy}, 6'd0);
        chk("rst_status", dma_status, 3'd0);
        chk("rst_pp_address", pp_address, 9'd0);
        JRSTN = 1'b1;
        tick();

        // Write burst N=3
        bus_grant = 1'b1;
        b0 = begin_cnt; e0 = end_cnt; bb = beats.size();
        launch(1'b1, 1'b0, 32'h0000_1000, 8'd3);
        chk("wr_switch_low", switch_ready, 1'b0);
        chk("wr_busy", dma_busy, 1'b1);
        wait_idle("wr_done");
        chk("wr_begin_cnt", begin_cnt - b0, 1);
        chk("wr_rnw", cap_rnw, 1'b0);
        chk("wr_addr", cap_addr, 32'h0000_1000);
        chk("wr_size", cap_size, 8'd3);
        chk("wr_be", cap_be, 4'hF);
        chk("wr_beat_cnt", beats.size() - bb, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("wr_beat%0d", i), beats[bb + i], 32'hA000_00A0 + i);
        chk("wr_end_cnt", end_cnt - e0, 1);
        chk("wr_switch_ready", switch_ready, 1'b1);
        chk("wr_status", dma_status, 3'd0);

        // Write with 2-cycle stall on beat 1
        bb = beats.size();
        launch(1'b1, 1'b0, 32'h0000_2000, 8'd3);
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            tick();
            n++;
            found = bus_data_valid && (bus_data_out == 32'hA000_00A1);
        end
        chk("stall_reach", found, 1'b1);
        bus_busy = 1'b1;
        tick();
        chk("stall_valid1", bus_data_valid, 1'b1);
        chk("stall_data1", bus_data_out, 32'hA000_00A1);
        tick();
        chk("stall_valid2", bus_data_valid, 1'b1);
        chk("stall_data2", bus_data_out, 32'hA000_00A1);
        bus_busy = 1'b0;
        wait_idle("stall_done");
        chk("stall_beat_cnt", beats.size() - bb, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("stall_beat%0d", i), beats[bb + i], 32'hA000_00A0 + i);

        // Read burst N=1 with 3 idle cycles between beats
        pw0 = pw_addr.size();
        b0 = begin_cnt;
        launch(1'b0, 1'b1, 32'h0000_3000, 8'd1);
        chk("rd_switch_low0", switch_ready, 1'b0);
        wait_begin("rd_begin");
        chk("rd_rnw", bus_read_nwrite, 1'b1);
        tick();
        bus_data_in = 32'hDEAD_BEEF; bus_data_in_valid = 1'b1;
        tick();
        bus_data_in_valid = 1'b0;
        repeat (3) tick();
        chk("rd_switch_low1", switch_ready, 1'b0);
        bus_data_in = 32'h1234_5678; bus_data_in_valid = 1'b1;
        tick();
        bus_data_in_valid = 1'b0;
        wait_idle("rd_done");
        chk("rd_pw_cnt", pw_addr.size() - pw0, 2);
        chk("rd_pw0_addr", pw_addr[pw0], 9'd0);
        chk("rd_pw0_data", pw_data[pw0], 32'hDEAD_BEEF);
        chk("rd_pw1_addr", pw_addr[pw0 + 1], 9'd1);
        chk("rd_pw1_data", pw_data[pw0 + 1], 32'h1234_5678);
        chk("rd_switch_ready", switch_ready, 1'b1);
        chk("rd_status", dma_status, 3'd0);

        // Simultaneous launches with grant delayed 5 cycles
        bus_grant = 1'b0;
        b0 = begin_cnt; bb = beats.size();
        launch(1'b1, 1'b1, 32'h0000_4000, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arb_req%0d", i), {bus_request, bus_begin}, 2'b10);
            tick();
        end
        chk("arb_req4", {bus_request, bus_begin}, 2'b10);
        bus_grant = 1'b1;
        wait_idle("arb_done");
        chk("arb_begin_cnt", begin_cnt - b0, 1);
        chk("arb_rnw", cap_rnw, 1'b0);
        chk("arb_beat", beats[bb], 32'hA000_00A0);
        chk("arb_status", dma_status, 3'd0);
        repeat (3) tick();
        chk("arb_read_dropped", dma_busy, 1'b0);

        // Second launch while in REQ
        bus_grant = 1'b0;
        launch(1'b1, 1'b0, 32'h0000_5000, 8'd0);
        launch(1'b0, 1'b1, 32'h0000_6000, 8'd0);
        chk("ovr_status", dma_status, 3'b100);
        bus_grant = 1'b1;
        wait_idle("ovr_done");
        chk("ovr_sticky", dma_status, 3'b100);
        chk("ovr_rnw", cap_rnw, 1'b0);

        // Bus error on the second read beat
        pw0 = pw_addr.size();
        launch(1'b0, 1'b1, 32'h0000_7000, 8'd3);
        wait_begin("err_begin");
        tick();
        bus_data_in = 32'h1111_1111; bus_data_in_valid = 1'b1;
        tick();
        bus_data_in = 32'h2222_2222; bus_error = 1'b1;
        tick();
        bus_data_in_valid = 1'b0; bus_error = 1'b0;
        chk("err_status", dma_status, 3'b001);
        wait_idle("err_done");
        chk("err_pw_cnt", pw_addr.size() - pw0, 1);
        chk("err_switch_ready", switch_ready, 1'b1);

        // Read with no beats: timeout lands on the 1025th edge after launch
        launch(1'b0, 1'b1, 32'h0000_8000, 8'd0);
        n = 0;
        while (!dma_status[1] && n < 2000) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 1025);
        chk("to_status", dma_status, 3'b010);
        wait_idle("to_done");

        // Reset in the middle of a write beat
        e0 = end_cnt;
        launch(1'b1, 1'b0, 32'h0000_9000, 8'd3);
        n = 0;
        while (!bus_data_valid && n < 50) begin
            tick();
            n++;
        end
        chk("mrst_in_beat", bus_data_valid, 1'b1);
        bus_busy = 1'b1;
        JRSTN = 1'b0;
        tick();
        chk("mrst_ctrl", {bus_request, bus_begin, bus_read_nwrite, bus_data_valid, bus_end, pp_writeEnable, dma_busy}, 7'd0);
        chk("mrst_status", dma_status, 3'd0);
        chk("mrst_data_out", bus_data_out, 32'd0);
        chk("mrst_addr_out", {bus_address_out, pp_address}, 41'd0);
        chk("mrst_switch_ready", switch_ready, 1'b1);
        JRSTN = 1'b1;
        bus_busy = 1'b0;
        repeat (5) tick();
        chk("mrst_no_end", end_cnt - e0, 0);
        chk("mrst_idle", dma_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
